// File: rtl/decode_stage.sv
// RV32I OP/OP-IMM decode stage: register file read, operand formation and a
// single-entry valid/ready output register holding the ALU operand bundle.
module decode_stage #(
   parameter bit BYPASS = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  funct3,
   output logic        mod,
   output logic [31:0] val1,
   output logic [31:0] val2,
   output logic [4:0]  rd,
   output logic        illegal,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   logic [31:0] rf [0:31];

   logic [6:0]  opcode;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;

   logic        dec_legal;
   logic        dec_mod;
   logic [31:0] dec_val1;
   logic [31:0] dec_val2;
   logic        accept;

   assign opcode   = instr[6:0];
   assign f3       = instr[14:12];
   assign rs1      = instr[19:15];
   assign rs2      = instr[24:20];
   assign f7       = instr[31:25];
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // x0 check comes last so a writeback aimed at x0 can never leak through the bypass
   always_comb begin
      rs1_val = rf[rs1];
      if (BYPASS && wb_en && (wb_rd == rs1)) rs1_val = wb_data;
      if (rs1 == '0) rs1_val = '0;
      rs2_val = rf[rs2];
      if (BYPASS && wb_en && (wb_rd == rs2)) rs2_val = wb_data;
      if (rs2 == '0) rs2_val = '0;
   end

   always_comb begin
      dec_legal = 1'b0;
      dec_mod   = 1'b0;
      dec_val1  = rs1_val;
      dec_val2  = '0;
      case (opcode)
         OPC_OP: begin
            dec_val2  = rs2_val;
            dec_mod   = instr[30];
            dec_legal = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
         end
         OPC_OPIMM: begin
            case (f3)
               3'b001: begin
                  dec_val2  = {27'b0, instr[24:20]};
                  dec_legal = (f7 == F7_BASE);
               end
               3'b101: begin
                  dec_val2  = {27'b0, instr[24:20]};
                  dec_mod   = instr[30];
                  dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
               end
               default: begin
                  dec_val2  = {{20{instr[31]}}, instr[31:20]};
                  dec_legal = 1'b1;
               end
            endcase
         end
         default: dec_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wb_en && (wb_rd != '0)) begin
         rf[wb_rd] <= wb_data;
      end
   end

   // illegal encodings still produce a bundle, with every operand field cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         funct3    <= '0;
         mod       <= 1'b0;
         val1      <= '0;
         val2      <= '0;
         rd        <= '0;
         illegal   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         funct3    <= dec_legal ? f3 : '0;
         mod       <= dec_legal && dec_mod;
         val1      <= dec_legal ? dec_val1 : '0;
         val2      <= dec_legal ? dec_val2 : '0;
         rd        <= dec_legal ? instr[11:7] : '0;
         illegal   <= !dec_legal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected bundles are queued at issue and a
// monitor pops and compares them whenever a bundle is consumed.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  funct3;
   logic        mod;
   logic [31:0] val1;
   logic [31:0] val2;
   logic [4:0]  rd;
   logic        illegal;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   typedef struct packed {
      logic [2:0]  f3;
      logic        m;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [4:0]  r;
      logic        ill;
   } bundle_t;

   bundle_t     q[$];
   bundle_t     cur;
   int unsigned nvec  = 0;
   int unsigned nfail = 0;

   always #5 clk = ~clk;

   decode_stage #(.BYPASS(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
      .funct3(funct3), .mod(mod), .val1(val1), .val2(val2), .rd(rd),
      .illegal(illegal), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   assign cur = {funct3, mod, val1, val2, rd, illegal};

   function automatic bundle_t mk(input logic [2:0] f3, input logic m,
                                  input logic [31:0] v1, input logic [31:0] v2,
                                  input logic [4:0] r, input logic ill);
      bundle_t b;
      b.f3 = f3; b.m = m; b.v1 = v1; b.v2 = v2; b.r = r; b.ill = ill;
      return b;
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // a bundle is consumed at the posedge following a negedge that shows valid && ready;
   // out_ready only ever changes just after a posedge, so the negedge view is exact
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL unexpected_bundle: got %h expected none", cur);
         end else begin
            check("bundle", cur, q.pop_front());
         end
      end
   end

   task automatic issue(input logic [31:0] i, input bundle_t e, input bit push);
      int n = 0;
      instr    = i;
      in_valid = 1'b1;
      if (push) q.push_back(e);
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         nvec++;
         nfail++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 for instr %h", i);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] d);
      wb_en = 1'b1; wb_rd = r; wb_data = d;
      @(posedge clk);
      #1 wb_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD;
      #3;
      check("reset_outputs", {out_valid, cur}, '0);
      check("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1 wb_en = 1'b0; rst_n = 1'b1;
      @(posedge clk);
      #1;

      // writeback during reset must not have reached x1
      issue(32'h000083B3, mk(3'b000, 1'b0, 32'd0, 32'd0, 5'd7, 1'b0), 1'b1);

      wb(5'd1, 32'd5);
      wb(5'd2, 32'd3);
      issue(32'h402081B3, mk(3'b000, 1'b1, 32'd5, 32'd3, 5'd3, 1'b0), 1'b1);
      issue(32'hFFF00213, mk(3'b000, 1'b0, 32'd0, 32'hFFFFFFFF, 5'd4, 1'b0), 1'b1);
      issue(32'h4040D293, mk(3'b101, 1'b1, 32'd5, 32'd4, 5'd5, 1'b0), 1'b1);

      // stall the SRAI bundle with a new instruction waiting
      out_ready = 1'b0;
      instr     = 32'h0020C433;
      in_valid  = 1'b1;
      q.push_back(mk(3'b100, 1'b0, 32'd5, 32'd3, 5'd8, 1'b0));
      repeat (4) begin
         @(negedge clk);
         check("hold_in_ready", in_ready, 0);
         check("hold_bundle", cur, mk(3'b101, 1'b1, 32'd5, 32'd4, 5'd5, 1'b0));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("b2b_first", {out_valid, rd}, {1'b1, 5'd8});
      issue(32'h0020F533, mk(3'b111, 1'b0, 32'd5, 32'd3, 5'd10, 1'b0), 1'b1);
      check("b2b_second", {out_valid, rd}, {1'b1, 5'd10});

      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
      issue(32'h00108333, mk(3'b000, 1'b0, 32'h1234, 32'h1234, 5'd6, 1'b0), 1'b1);
      wb_en = 1'b0;

      wb(5'd0, 32'hFFFF);
      issue(32'h000005B3, mk(3'b000, 1'b0, 32'd0, 32'd0, 5'd11, 1'b0), 1'b1);

      issue(32'h0000007F, mk(3'b000, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1), 1'b1);
      issue(32'h40309613, mk(3'b000, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1), 1'b1);
      issue(32'h40209433, mk(3'b000, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1), 1'b1);
      issue(32'h7FF10693, mk(3'b000, 1'b0, 32'd3, 32'h7FF, 5'd13, 1'b0), 1'b1);

      // let the last bundle drain, then park one and reset underneath it
      @(posedge clk);
      #1 out_ready = 1'b0;
      issue(32'hFFF00213, mk(3'b000, 1'b0, 32'd0, 32'hFFFFFFFF, 5'd4, 1'b0), 1'b0);
      check("parked_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {out_valid, cur}, '0);
      check("async_reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1 rst_n = 1'b1; out_ready = 1'b1;
      issue(32'h000083B3, mk(3'b000, 1'b0, 32'd0, 32'd0, 5'd7, 1'b0), 1'b1);

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter BYPASS, default 1: when 1, a same-cycle writeback is forwarded to operand reads.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid  input  1  instr holds a valid instruction.
REQ-005 The block SHALL have port in_ready  output  1  block accepts instr this cycle.
REQ-006 The block SHALL have port instr  input  32  RV32I instruction word.
REQ-007 The block SHALL have port out_valid  output  1  ALU operand bundle valid.
REQ-008 The block SHALL have port out_ready  input  1  downstream ALU stage consumes the bundle.
REQ-009 The block SHALL have ports funct3 (output, 3 bits) and mod (output, 1 bit), which drive the ALU operation select directly.
REQ-010 The block SHALL have ports val1 and val2 (output, 32 bits each): the ALU operands.
REQ-011 The block SHALL have ports rd (output, 5 bits): destination register; and illegal (output, 1 bit): the instruction is not a legal OP/OP-IMM.
REQ-012 The block SHALL have ports wb_en (input, 1 bit), wb_rd (input, 5 bits) and wb_data (input, 32 bits): the register-file write port from writeback.

Function
REQ-013 The block SHALL contain a 32x32 register file; reads of x0 SHALL return 0, and writes to x0 SHALL be ignored.
REQ-014 The register file SHALL write wb_data to wb_rd on a rising edge where wb_en=1.
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-016 An accept SHALL occur when in_valid && in_ready; on an accept, all outputs SHALL load the decoded bundle and out_valid SHALL become 1 on the next edge (1-cycle latency).
REQ-017 On a rising edge with out_valid && out_ready and no accept, out_valid SHALL become 0.
REQ-018 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-019 Field extraction: opcode=instr[6:0], rd=instr[11:7], funct3=instr[14:12], rs1=instr[19:15], rs2=instr[24:20].
REQ-020 OP (0110011): val1=rf[rs1], val2=rf[rs2], mod=instr[30]; legal only if instr[31:25]=0000000, or instr[31:25]=0100000 with funct3 in {000,101}.
REQ-021 OP-IMM (0010011), funct3 not 001/101: val2=sign-extend(instr[31:20]) to 32 bits, mod=0.
REQ-022 OP-IMM funct3=001: val2={27'b0,instr[24:20]}, mod=0; legal only if instr[31:25]=0000000.
REQ-023 OP-IMM funct3=101: val2={27'b0,instr[24:20]}, mod=instr[30]; legal only if instr[31:25] is 0000000 or 0100000.
REQ-024 For OP-IMM, val1 SHALL equal rf[rs1].
REQ-025 Any other opcode or illegal encoding SHALL still be accepted and output with illegal=1, funct3=0, mod=0, val1=0, val2=0, rd=0.
REQ-026 With BYPASS=1, when wb_en=1 and wb_rd equals a nonzero rs1/rs2 in the accept cycle, the read SHALL return wb_data; with BYPASS=0 it SHALL return the pre-write value.
REQ-027 Simultaneous accept and consume SHALL keep out_valid=1 and load the new bundle with no bubble.

Reset
REQ-028 While rst_n=0, out_valid, funct3, mod, val1, val2, rd and illegal SHALL be 0, and all registers SHALL be 0.
REQ-029 Reset assertion mid-operation SHALL discard any held bundle immediately; in_ready SHALL be 1 after reset.
REQ-030 A writeback asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-031 Write x1=5, x2=3; issue SUB x3,x1,x2 (0x402081B3) -> next cycle out_valid=1, funct3=000, mod=1, val1=5, val2=3, rd=3.
REQ-032 Issue ADDI x4,x0,-1 (0xFFF00213) -> val1=0, val2=0xFFFFFFFF, mod=0, funct3=000, rd=4; SRAI x5,x1,4 (0x4040D293) -> val2=4, mod=1, funct3=101.
REQ-033 Hold out_ready=0 with a bundle pending -> in_ready=0 and outputs unchanged for 3 cycles; then raise out_ready with in_valid=1 -> back-to-back bundles with no bubble.
REQ-034 wb_en=1, wb_rd=1, wb_data=0x1234 in the same cycle ADD x6,x1,x1 is accepted -> val1=val2=0x1234 (BYPASS=1); a write to x0 followed by a read of x0 -> 0.
REQ-035 Issue opcode 0x0000007F, then SLLI with instr[31:25]=0100000 -> illegal=1 with all operand fields 0 in both cases.
REQ-036 Drop rst_n while out_valid=1 -> out_valid=0 without waiting for a clock edge, and rf[1] reads 0 afterwards.
